watch_date_uart_tx: RTL and testbench

Reader side of the watch time/date register set. It snapshots the six binary fields (year, month, day, hour, minute, second) on each 1-second tick and transmits them over UART 8N1 as one fixed-length ASCII line: "YY-MM-DD hh:mm:ss" followed by CR and LF, 19 characters in total. It sits beside the watch counter and drives the board's debug/host serial pin.

---
 rtl/watch_date_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_watch_date_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/watch_date_uart_tx.sv
// Snapshots the six watch fields on a 1 s tick and sends them over UART 8N1
// as the 19-character line "YY-MM-DD hh:mm:ss\r\n".
module watch_date_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1sec,
  input  logic [7:0] year,
  input  logic [7:0] month,
  input  logic [7:0] day,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  output logic       tx,
  output logic       busy,
  output logic       frame_drop
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } stamp_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   timer, timer_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [4:0]      char_idx, char_idx_d;
  stamp_t          snap;
  logic [7:0]      cur_char;
  logic            tx_d;
  logic            bit_end;
  logic            snap_en;

  // Values above 99 wrap to their low two decimal digits.
  function automatic logic [7:0] dig_hi(input logic [7:0] v);
    return 8'h30 + (v / 8'd10) % 8'd10;
  endfunction

  function automatic logic [7:0] dig_lo(input logic [7:0] v);
    return 8'h30 + v % 8'd10;
  endfunction

  assign busy       = (state != IDLE);
  assign frame_drop = clk1sec & busy;
  assign snap_en    = clk1sec & (state == IDLE);
  assign bit_end    = (timer == T_LAST);

  always_comb begin
    state_d    = state;
    timer_d    = timer;
    bit_idx_d  = bit_idx;
    char_idx_d = char_idx;
    case (state)
      IDLE: begin
        if (clk1sec) begin
          state_d    = START;
          timer_d    = '0;
          bit_idx_d  = '0;
          char_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (char_idx == 5'd18) begin
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx + 5'd1;
            state_d    = START;
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx_d)
      5'd0:  cur_char = dig_hi(snap.year);
      5'd1:  cur_char = dig_lo(snap.year);
      5'd2:  cur_char = 8'h2D;
      5'd3:  cur_char = dig_hi(snap.month);
      5'd4:  cur_char = dig_lo(snap.month);
      5'd5:  cur_char = 8'h2D;
      5'd6:  cur_char = dig_hi(snap.day);
      5'd7:  cur_char = dig_lo(snap.day);
      5'd8:  cur_char = 8'h20;
      5'd9:  cur_char = dig_hi(snap.hour);
      5'd10: cur_char = dig_lo(snap.hour);
      5'd11: cur_char = 8'h3A;
      5'd12: cur_char = dig_hi(snap.minute);
      5'd13: cur_char = dig_lo(snap.minute);
      5'd14: cur_char = 8'h3A;
      5'd15: cur_char = dig_hi(snap.second);
      5'd16: cur_char = dig_lo(snap.second);
      5'd17: cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  // tx is computed from the next state so the registered line bit lines up
  // with the state it belongs to (start bit appears right after the snapshot).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_char[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      snap     <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      bit_idx  <= bit_idx_d;
      char_idx <= char_idx_d;
      tx       <= tx_d;
      if (snap_en) snap <= {year, month, day, hour, minute, second};
    end
  end

endmodule

// File: tb/tb_watch_date_uart_tx.sv
// Directed bench for watch_date_uart_tx: decodes whole frames at CLKS_PER_BIT=4
// and checks bit timing of a second instance at CLKS_PER_BIT=434.
module tb_watch_date_uart_tx;
  localparam int CPB   = 4;
  localparam int FLEN  = 190 * CPB;

  logic       clk = 1'b0;
  logic       rst, rst2, clk1sec, tick2;
  logic [7:0] year, month, day, hour, minute, second;
  logic       tx, busy, frame_drop;
  logic       tx2, busy2, drop2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  watch_date_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .tx(tx), .busy(busy), .frame_drop(frame_drop)
  );

  watch_date_uart_tx #(.CLKS_PER_BIT(434)) dut2 (
    .clk(clk), .rst(rst2), .clk1sec(tick2),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .tx(tx2), .busy(busy2), .frame_drop(drop2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_f(input logic [7:0] y, mo, d, h, mi, s);
    year = y; month = mo; day = d; hour = h; minute = mi; second = s;
  endtask

  task automatic tick();
    @(negedge clk); clk1sec = 1'b1;
    @(negedge clk); clk1sec = 1'b0;
  endtask

  // Called on the negedge right after a tick; records one full frame of tx.
  task automatic cap(input string exp, input int drop_at, input int chg_at,
                     input int exp_drops, input bit b2b);
    logic       samp [0:FLEN-1];
    logic [7:0] ch, ec;
    int bcnt, dcnt, bad;
    bcnt = 0; dcnt = 0; bad = 0;
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) clk1sec = 1'b1;
      if (drop_at >= 0 && k == drop_at + 1) clk1sec = 1'b0;
      if (k == chg_at) set_f(8'd42, 8'd6, 8'd17, 8'd8, 8'd45, 8'd3);
      #1;
      samp[k] = tx;
      bcnt += int'(busy);
      dcnt += int'(frame_drop);
      if (k == 0) begin
        chk("start_latency_tx", tx, 1'b0);
        chk("start_latency_busy", busy, 1'b1);
      end
    end
    for (int c = 0; c < 19; c++) begin
      ch = 8'h00;
      for (int b = 0; b < 10; b++) begin
        for (int j = 1; j < CPB; j++)
          if (samp[c*40 + b*CPB + j] !== samp[c*40 + b*CPB]) bad++;
        if (b == 0 && samp[c*40] !== 1'b0) bad++;
        if (b == 9 && samp[c*40 + 9*CPB] !== 1'b1) bad++;
        if (b >= 1 && b <= 8) ch[b-1] = samp[c*40 + b*CPB];
      end
      if (c < 17) ec = exp[c];
      else ec = (c == 17) ? 8'h0D : 8'h0A;
      chk($sformatf("char%0d", c), ch, ec);
    end
    chk("framing_errs", bad, 0);
    chk("busy_cycles", bcnt, FLEN);
    chk("drop_pulses", dcnt, exp_drops);
    @(negedge clk);
    if (b2b) clk1sec = 1'b1;
    #1;
    chk("busy_fall", busy, 1'b0);
    chk("idle_no_drop", frame_drop, 1'b0);
    if (b2b) begin
      @(negedge clk);
      clk1sec = 1'b0;
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    int lows, bsy;
    lows = 0; bsy = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      lows += int'(!tx);
      bsy  += int'(busy);
    end
    chk({tag, "_tx_low"}, lows, 0);
    chk({tag, "_busy"}, bsy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; rst2 = 1'b0; clk1sec = 1'b0; tick2 = 1'b0;
    set_f(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", frame_drop, 1'b0);
    chk("rst_tx2", tx2, 1'b1);
    rst = 1'b1; rst2 = 1'b1;
    idle_watch("post_rst", 5);

    // basic frame
    set_f(8'd21, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0);
    tick();
    cap("21-05-30 00:00:00", -1, -1, 0, 1'b0);

    // wide values wrap to two digits
    set_f(8'd255, 8'd100, 8'd9, 8'd23, 8'd59, 8'd59);
    tick();
    cap("55-00-09 23:59:59", -1, -1, 0, 1'b0);

    // overrun tick 100 cycles in
    set_f(8'd12, 8'd12, 8'd31, 8'd11, 8'd22, 8'd33);
    tick();
    cap("12-12-31 11:22:33", 100, -1, 1, 1'b0);
    idle_watch("overrun_idle", 60);

    // inputs change after snapshot
    set_f(8'd99, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    tick();
    cap("99-01-02 03:04:05", -1, 10, 0, 1'b0);

    // back-to-back: second frame picks up the changed inputs
    set_f(8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12);
    tick();
    cap("07-08-09 10:11:12", -1, 10, 0, 1'b1);
    cap("42-06-17 08:45:03", -1, -1, 0, 1'b0);

    // reset mid-frame
    set_f(8'd21, 8'd5, 8'd30, 8'd0, 8'd0, 8'd0);
    tick();
    repeat (300) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_watch("after_rst", 20);
    tick();
    cap("21-05-30 00:00:00", -1, -1, 0, 1'b0);

    // long bit time: reset lands inside a start bit, then measure bit widths
    set_f(8'd11, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("slow_pre_rst_tx", tx2, 1'b0);
    rst2 = 1'b0;
    #1;
    chk("slow_rst_tx", tx2, 1'b1);
    chk("slow_rst_busy", busy2, 1'b0);
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("slow_idle_tx", tx2, 1'b1);
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    #1;
    chk("slow_busy", busy2, 1'b1);
    n = 0;
    while (tx2 == 1'b0 && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    chk("slow_start_width", n, 434);
    n = 0;
    while (tx2 == 1'b1 && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    chk("slow_bit0_width", n, 434);
    rst2 = 1'b0;
    #1;
    chk("slow_abort_busy", busy2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
